// File: rtl/sa_cache_nway.sv
// N-way set-associative write-back cache with 128-bit lines, accessed-bit replacement
// and a single outstanding memory transaction; arrays are invalidated by an INIT sweep.
module sa_cache_nway #(
  parameter int WAYS  = 4,
  parameter int INDEX = 12,
  parameter int TAG   = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [31:0]  cpu_req_addr,
  input  logic [31:0]  cpu_req_data,
  input  logic [3:0]   cpu_req_wstrb,
  input  logic         cpu_req_rw,
  input  logic         cpu_req_valid,
  input  logic [127:0] mem_res_data,
  input  logic         mem_res_ready,
  output logic [31:0]  mem_req_addr,
  output logic [127:0] mem_req_data,
  output logic         mem_req_rw,
  output logic         mem_req_valid,
  output logic [31:0]  cpu_res_data,
  output logic         cpu_res_ready,
  output logic         busy
);
  localparam int SETS = 1 << INDEX;
  localparam int TW   = TAG + 3;
  localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [2:0] INIT       = 3'd0;
  localparam logic [2:0] IDLE       = 3'd1;
  localparam logic [2:0] COMPARE    = 3'd2;
  localparam logic [2:0] WRITE_BACK = 3'd3;
  localparam logic [2:0] ALLOCATE   = 3'd4;
  localparam logic [2:0] RESPOND    = 3'd5;

  logic [2:0]       state;
  logic [INDEX-1:0] init_cnt;
  logic [WW-1:0]    hit_way;
  logic [WW-1:0]    vict_way;

  logic [INDEX-1:0] req_index;
  logic [TAG-1:0]   req_tag;
  logic [6:0]       word_base;
  logic [INDEX-1:0] arr_idx;
  logic             unused_addr_bits;

  assign req_index        = cpu_req_addr[INDEX+3:4];
  assign req_tag          = cpu_req_addr[31:INDEX+4];
  assign word_base        = {cpu_req_addr[3:2], 5'd0};
  assign arr_idx          = (state == INIT) ? init_cnt : req_index;
  assign unused_addr_bits = ^cpu_req_addr[1:0];

  // Tag entry layout: {accessed, valid, dirty, tag}
  logic [TW-1:0]   tag_rd [WAYS];
  logic [TW-1:0]   tag_wd [WAYS];
  logic            tag_we;
  logic [127:0]    data_rd [WAYS];
  logic [127:0]    data_wd;
  logic [WAYS-1:0] data_we;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [TW-1:0]  tag_mem  [SETS];
    logic [127:0]   data_mem [SETS];
    logic [TW-1:0]  tag_q;
    logic [127:0]   data_q;

    always_ff @(posedge clk) begin
      if (tag_we) begin
        tag_mem[arr_idx] <= tag_wd[w];
        tag_q            <= tag_wd[w];
      end else begin
        tag_q <= tag_mem[arr_idx];
      end
      if (data_we[w]) begin
        data_mem[arr_idx] <= data_wd;
        data_q            <= data_wd;
      end else begin
        data_q <= data_mem[arr_idx];
      end
    end

    assign tag_rd[w]  = tag_q;
    assign data_rd[w] = data_q;
  end

  logic            hit;
  logic [WW-1:0]   hit_idx;
  logic            inv_any;
  logic [WW-1:0]   inv_idx;
  logic            free_any;
  logic [WW-1:0]   free_idx;
  logic [WW-1:0]   victim;

  // Descending scan so the lowest-index candidate is the one left standing.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    inv_any  = 1'b0;
    inv_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (tag_rd[w][TAG+1] && (tag_rd[w][TAG-1:0] == req_tag)) begin
        hit     = 1'b1;
        hit_idx = WW'(w);
      end
      if (!tag_rd[w][TAG+1]) begin
        inv_any = 1'b1;
        inv_idx = WW'(w);
      end
      if (!tag_rd[w][TAG+2]) begin
        free_any = 1'b1;
        free_idx = WW'(w);
      end
    end
    victim = inv_any ? inv_idx : (free_any ? free_idx : '0);
  end

  logic [WW-1:0]   touch;
  logic [WAYS-1:0] acc_next;

  always_comb begin
    touch    = (state == ALLOCATE) ? vict_way : hit_idx;
    acc_next = '0;
    for (int w = 0; w < WAYS; w++) begin
      acc_next[w] = tag_rd[w][TAG+2] || (WW'(w) == touch);
    end
    if (&acc_next) begin
      acc_next        = '0;
      acc_next[touch] = 1'b1;
    end
  end

  logic [127:0] hit_line;
  logic [127:0] merged_line;
  logic [31:0]  old_word;
  logic [31:0]  new_word;

  always_comb begin
    hit_line = data_rd[hit_idx];
    old_word = hit_line[word_base +: 32];
    for (int b = 0; b < 4; b++) begin
      new_word[b*8 +: 8] = cpu_req_wstrb[b] ? cpu_req_data[b*8 +: 8] : old_word[b*8 +: 8];
    end
    merged_line                  = hit_line;
    merged_line[word_base +: 32] = new_word;
  end

  always_comb begin
    tag_we  = 1'b0;
    data_we = '0;
    data_wd = merged_line;
    for (int w = 0; w < WAYS; w++) begin
      tag_wd[w] = {acc_next[w], tag_rd[w][TAG+1:0]};
    end
    case (state)
      INIT: begin
        tag_we = 1'b1;
        for (int w = 0; w < WAYS; w++) tag_wd[w] = '0;
      end
      COMPARE: begin
        if (hit) begin
          tag_we                   = 1'b1;
          tag_wd[hit_idx][TAG]     = tag_rd[hit_idx][TAG] | cpu_req_rw;
          data_we[hit_idx]         = cpu_req_rw;
        end
      end
      ALLOCATE: begin
        if (mem_res_ready) begin
          tag_we            = 1'b1;
          tag_wd[vict_way]  = {1'b1, 1'b1, 1'b0, req_tag};
          data_we[vict_way] = 1'b1;
          data_wd           = mem_res_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= INIT;
      init_cnt      <= '0;
      hit_way       <= '0;
      vict_way      <= '0;
      mem_req_valid <= 1'b0;
      mem_req_rw    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_data  <= '0;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (&init_cnt) state <= IDLE;
        end
        IDLE: begin
          if (cpu_req_valid) state <= COMPARE;
        end
        COMPARE: begin
          if (hit) begin
            hit_way <= hit_idx;
            state   <= RESPOND;
          end else begin
            vict_way      <= victim;
            mem_req_valid <= 1'b1;
            if (tag_rd[victim][TAG+1] && tag_rd[victim][TAG]) begin
              mem_req_rw   <= 1'b1;
              mem_req_addr <= {tag_rd[victim][TAG-1:0], req_index, 4'b0};
              mem_req_data <= data_rd[victim];
              state        <= WRITE_BACK;
            end else begin
              mem_req_rw   <= 1'b0;
              mem_req_addr <= {req_tag, req_index, 4'b0};
              state        <= ALLOCATE;
            end
          end
        end
        WRITE_BACK: begin
          if (mem_res_ready) begin
            mem_req_rw   <= 1'b0;
            mem_req_addr <= {req_tag, req_index, 4'b0};
            state        <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (mem_res_ready) begin
            mem_req_valid <= 1'b0;
            state         <= COMPARE;
          end
        end
        RESPOND: state <= IDLE;
        default: state <= INIT;
      endcase
    end
  end

  logic [127:0] resp_line;
  assign resp_line     = data_rd[hit_way];
  assign cpu_res_ready = (state == RESPOND);
  assign cpu_res_data  = (state == RESPOND) ? resp_line[word_base +: 32] : 32'd0;
  // Gated by rstn so every output reads zero while reset is held.
  assign busy          = rstn & (state != IDLE);

endmodule

// File: tb/tb_sa_cache_nway.sv
// Scoreboard bench for sa_cache_nway (4 ways, 16 sets): directed CPU requests with a
// responding memory model; separate monitors pop expected CPU and memory traffic.
module tb_sa_cache_nway;
  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [31:0]  cpu_req_addr = '0;
  logic [31:0]  cpu_req_data = '0;
  logic [3:0]   cpu_req_wstrb = '0;
  logic         cpu_req_rw = 1'b0;
  logic         cpu_req_valid = 1'b0;
  logic [127:0] mem_res_data = '0;
  logic         mem_res_ready = 1'b0;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_req_rw;
  logic         mem_req_valid;
  logic [31:0]  cpu_res_data;
  logic         cpu_res_ready;
  logic         busy;

  sa_cache_nway #(.WAYS(4), .INDEX(4), .TAG(24)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_req_data  (cpu_req_data),
    .cpu_req_wstrb (cpu_req_wstrb),
    .cpu_req_rw    (cpu_req_rw),
    .cpu_req_valid (cpu_req_valid),
    .mem_res_data  (mem_res_data),
    .mem_res_ready (mem_res_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_data  (mem_req_data),
    .mem_req_rw    (mem_req_rw),
    .mem_req_valid (mem_req_valid),
    .cpu_res_data  (cpu_res_data),
    .cpu_res_ready (cpu_res_ready),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          issue;
  } cpu_exp_t;

  typedef struct {
    logic         rw;
    logic [31:0]  addr;
    logic [127:0] data;
    bit           noresp;
  } mem_exp_t;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Memory returns word k of line L as L + 4k + 0x10000000.
  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:4], 4'b0} + 32'h1000_0000;
    return {b + 32'd12, b + 32'd8, b + 32'd4, b};
  endfunction

  task automatic expectMem(input logic rw, input logic [31:0] addr, input logic [127:0] data, input bit noresp);
    mem_exp_t m;
    m.rw = rw;
    m.addr = addr;
    m.data = data;
    m.noresp = noresp;
    mem_q.push_back(m);
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                               input logic rw, input logic [31:0] exp_data, input int lat);
    cpu_exp_t e;
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    e.data = exp_data;
    e.lat = lat;
    e.issue = cyc;
    cpu_q.push_back(e);
    cpu_req_addr = addr;
    cpu_req_data = wdata;
    cpu_req_wstrb = wstrb;
    cpu_req_rw = rw;
    cpu_req_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!cpu_res_ready && t < 300);
    if (!cpu_res_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL response timeout: addr %h got no cpu_res_ready, required one within %0d cycles", addr, t);
    end
    cpu_req_valid = 1'b0;
    cpu_req_rw = 1'b0;
  endtask

  task automatic checkSweep(input string name);
    int n;
    n = 0;
    #1;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput(name, n, 16);
  endtask

  // CPU-side monitor.
  initial begin
    cpu_exp_t ce;
    forever begin
      @(negedge clk);
      if (cpu_res_ready) begin
        if (cpu_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected cpu_res_ready: data %h, required no response", cpu_res_data);
        end else begin
          ce = cpu_q.pop_front();
          checkOutput("cpu_res_data", cpu_res_data, ce.data);
          if (ce.lat >= 0) checkOutput("hit latency", cyc - ce.issue, ce.lat);
        end
      end
    end
  end

  // Memory-side monitor and responder.
  initial begin
    mem_exp_t m;
    bit expected_req;
    int t;
    forever begin
      @(negedge clk);
      if (mem_req_valid && rstn) begin
        expected_req = (mem_q.size() != 0);
        if (!expected_req) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected mem request: rw %b addr %h, required none", mem_req_rw, mem_req_addr);
          m.rw = mem_req_rw;
          m.noresp = 1'b0;
        end else begin
          m = mem_q.pop_front();
          checkOutput("mem_req_rw", mem_req_rw, m.rw);
          checkOutput("mem_req_addr", mem_req_addr, m.addr);
          if (m.rw) checkOutput("mem_req_data", mem_req_data, m.data);
        end
        if (m.noresp) begin
          t = 0;
          while (mem_req_valid && t < 100) begin
            @(negedge clk);
            t++;
          end
        end else begin
          repeat (2) @(negedge clk);
          if (expected_req) begin
            checkOutput("mem_req_valid held", mem_req_valid, 1);
            checkOutput("mem_req_addr held", mem_req_addr, m.addr);
          end
          mem_res_data = line_of(mem_req_addr);
          mem_res_ready = 1'b1;
          @(negedge clk);
          mem_res_ready = 1'b0;
          mem_res_data = '0;
          if (!m.rw) checkOutput("mem_req_valid drop", mem_req_valid, 0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached before the run completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset mem_req_valid", mem_req_valid, 0);
    checkOutput("reset cpu_res_ready", cpu_res_ready, 0);
    checkOutput("reset cpu_res_data", cpu_res_data, 0);
    checkOutput("reset mem_req_addr", mem_req_addr, 0);
    rstn = 1'b1;
    checkSweep("init busy cycles");

    // Set 0 traffic: refill, hits, partial write merge.
    expectMem(1'b0, 32'h0000_0100, '0, 1'b0);
    applyStimulus(32'h0000_0100, 32'h0, 4'h0, 1'b0, 32'h1000_0100, -1);
    applyStimulus(32'h0000_0104, 32'h0, 4'h0, 1'b0, 32'h1000_0104, 2);
    applyStimulus(32'h0000_0104, 32'h0, 4'h0, 1'b0, 32'h1000_0104, 2);
    applyStimulus(32'h0000_0108, 32'h3333_3333, 4'hF, 1'b1, 32'h3333_3333, 2);
    applyStimulus(32'h0000_0108, 32'hDEAD_BEEF, 4'h3, 1'b1, 32'h3333_BEEF, 2);
    applyStimulus(32'h0000_0108, 32'h0, 4'h0, 1'b0, 32'h3333_BEEF, 2);

    // Write miss in set 1 merges into the freshly filled line.
    expectMem(1'b0, 32'h0000_0710, '0, 1'b0);
    applyStimulus(32'h0000_0714, 32'hCAFE_F00D, 4'hC, 1'b1, 32'hCAFE_0714, -1);

    // Fill ways 1..3 of set 0; the fourth fill leaves only way 3 accessed.
    expectMem(1'b0, 32'h0000_0200, '0, 1'b0);
    applyStimulus(32'h0000_0200, 32'h0, 4'h0, 1'b0, 32'h1000_0200, -1);
    expectMem(1'b0, 32'h0000_0300, '0, 1'b0);
    applyStimulus(32'h0000_0300, 32'h0, 4'h0, 1'b0, 32'h1000_0300, -1);
    expectMem(1'b0, 32'h0000_0400, '0, 1'b0);
    applyStimulus(32'h0000_0400, 32'h0, 4'h0, 1'b0, 32'h1000_0400, -1);

    // Fifth tag evicts dirty way 0: write-back of tag 1, then refill.
    expectMem(1'b1, 32'h0000_0100, 128'h1000_010C_3333_BEEF_1000_0104_1000_0100, 1'b0);
    expectMem(1'b0, 32'h0000_0500, '0, 1'b0);
    applyStimulus(32'h0000_0500, 32'h0, 4'h0, 1'b0, 32'h1000_0500, -1);
    expectMem(1'b0, 32'h0000_0600, '0, 1'b0);
    applyStimulus(32'h0000_0600, 32'h0, 4'h0, 1'b0, 32'h1000_0600, -1);
    applyStimulus(32'h0000_0300, 32'h0, 4'h0, 1'b0, 32'h1000_0300, 2);
    applyStimulus(32'h0000_0500, 32'h0, 4'h0, 1'b0, 32'h1000_0500, 2);
    expectMem(1'b0, 32'h0000_0200, '0, 1'b0);
    applyStimulus(32'h0000_0200, 32'h0, 4'h0, 1'b0, 32'h1000_0200, -1);

    // Reset while ALLOCATE waits for the refill.
    begin
      int t;
      expectMem(1'b0, 32'h0000_0820, '0, 1'b1);
      @(negedge clk);
      cpu_req_addr = 32'h0000_0820;
      cpu_req_rw = 1'b0;
      cpu_req_valid = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!mem_req_valid && t < 50);
      checkOutput("refill pending before reset", mem_req_valid, 1);
      @(negedge clk);
      #2;
      rstn = 1'b0;
      cpu_req_valid = 1'b0;
      #1;
      checkOutput("mem_req_valid at reset", mem_req_valid, 0);
      checkOutput("cpu_res_ready at reset", cpu_res_ready, 0);
      checkOutput("busy at reset", busy, 0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      checkSweep("re-init busy cycles");
    end

    expectMem(1'b0, 32'h0000_0100, '0, 1'b0);
    applyStimulus(32'h0000_0104, 32'h0, 4'h0, 1'b0, 32'h1000_0104, -1);

    repeat (10) @(negedge clk);
    checkOutput("cpu queue drained", cpu_q.size(), 0);
    checkOutput("mem queue drained", mem_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
